// File: rtl/seq_divmod_pkg.sv
// Shared definitions for the sequential divider: state encoding and a clog2 helper.
package seq_divmod_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/seq_divmod_if.sv
// Handshake and operand/result bundle between the datapath controller and the divider.
interface seq_divmod_if #(
   parameter int WIDTH = 8
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quot;
   logic [WIDTH-1:0] rem;
   logic             div_by_zero;

   modport master (
      output start, a, b,
      input  busy, done, quot, rem, div_by_zero
   );

   modport slave (
      input  start, a, b,
      output busy, done, quot, rem, div_by_zero
   );

endinterface

// File: rtl/seq_divmod_step.sv
// One restoring-division iteration: shift in the next dividend bit and trial-subtract.
module divmod_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   prem_in,
   input  logic             msb,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   prem_out,
   output logic             qbit
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;

   // Trial subtraction; a bit shifted out of the top means the value certainly exceeds the divisor.
   always_comb begin
      shifted  = {prem_in[WIDTH-1:0], msb};
      diff     = {1'b0, shifted} - {2'b00, divisor};
      qbit     = prem_in[WIDTH] | ~diff[WIDTH+1];
      prem_out = qbit ? diff[WIDTH:0] : shifted;
   end

endmodule

// File: rtl/seq_divmod.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
module seq_divmod
   import seq_divmod_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic         Clk,
   input logic         Rst,
   seq_divmod_if.slave bus
);

   localparam int CW = clog2(WIDTH) + 1;

   state_t           state;
   state_t           state_next;
   logic             accept;
   logic             last_iter;

   // The dividend register shifts out from the top while quotient bits enter at the bottom.
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH:0]   prem;
   logic [WIDTH:0]   prem_next;
   logic [CW-1:0]    cnt;
   logic             qbit;

   logic             busy_r;
   logic             done_r;
   logic             dbz_r;
   logic [WIDTH-1:0] quot_r;
   logic [WIDTH-1:0] rem_r;

   divmod_step #(.WIDTH(WIDTH)) u_step (
      .prem_in  (prem),
      .msb      (dvd[WIDTH-1]),
      .divisor  (dvs),
      .prem_out (prem_next),
      .qbit     (qbit)
   );

   assign last_iter = (cnt == CW'(WIDTH - 1));

   // Next-state logic and accept decode.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               accept     = 1'b1;
               state_next = (bus.b == '0) ? DONE : CALC;
            end else begin
               state_next = IDLE;
            end
         end
         CALC: begin
            if (last_iter) begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register with registered busy/done flags decoded from the next state.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state  <= IDLE;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         state  <= state_next;
         busy_r <= (state_next == CALC);
         done_r <= (state_next == DONE);
      end
   end

   // Operand capture, iteration datapath and result registers.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         dvd    <= '0;
         dvs    <= '0;
         prem   <= '0;
         cnt    <= '0;
         quot_r <= '0;
         rem_r  <= '0;
         dbz_r  <= 1'b0;
      end else if (accept) begin
         dvd  <= bus.a;
         dvs  <= bus.b;
         prem <= '0;
         cnt  <= '0;
         if (bus.b == '0) begin
            quot_r <= '1;
            rem_r  <= bus.a;
            dbz_r  <= 1'b1;
         end
      end else if (state == CALC) begin
         prem <= prem_next;
         dvd  <= {dvd[WIDTH-2:0], qbit};
         cnt  <= cnt + 1'b1;
         if (last_iter) begin
            quot_r <= {dvd[WIDTH-2:0], qbit};
            rem_r  <= prem_next[WIDTH-1:0];
            dbz_r  <= 1'b0;
         end
      end
   end

   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.quot        = quot_r;
   assign bus.rem         = rem_r;
   assign bus.div_by_zero = dbz_r;

endmodule
